// File: rtl/arm_dmem_pkg.sv
// Shared types and geometry for the MEM-stage data-memory responder.
//   ADDR_W   : word-address bits decoded (array depth 2**ADDR_W words)
//   WB_DEPTH : write-buffer entries (power of 2, >= 2)
// The geometry lives here rather than as module parameters so that
// wb_entry_t and every user of it always agree on the address width.
package arm_dmem_pkg;

  localparam int ADDR_W   = 10;
  localparam int WB_DEPTH = 4;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int PTR_W    = $clog2(WB_DEPTH);
  localparam int CNT_W    = $clog2(WB_DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } wb_entry_t;

  typedef enum logic {
    DM_INIT,
    DM_RUN
  } dmem_state_t;

  // Replace the byte lanes of old_word selected by be with those of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/arm_dmem_wbuf.sv
// Posted-store write buffer: a WB_DEPTH-entry FIFO of {addr, data, be}
// plus a forwarding lookup that overlays buffered bytes on an array word.
//   clk, rst            : clock, asynchronous active-high reset
//   push, push_*        : enqueue one store at the tail
//   pop                 : retire the head entry (caller guarantees count>0)
//   lookup_addr/base    : address being read and the raw array word there
//   lookup_data         : base with all matching buffered lanes applied
//   head_addr/data/be   : head entry, used by the caller to drain
//   count               : occupancy, 0..WB_DEPTH
module arm_dmem_wbuf
  import arm_dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [31:0]       push_data,
  input  logic [3:0]        push_be,
  input  logic              pop,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic [31:0]       lookup_base,
  output logic [31:0]       lookup_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic [31:0]       head_data,
  output logic [3:0]        head_be,
  output logic [CNT_W-1:0]  count
);

  wb_entry_t        entries_q [WB_DEPTH];
  wb_entry_t        entries_d [WB_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every signal assigned in an always_comb gets a default at the top
  // of the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (pop) begin
      entries_d[head_q] = '0;
      head_d            = head_q + 1'b1;
    end

    // Push after pop: when full, the freed head slot is the tail slot.
    if (push) begin
      entries_d[tail_q] = '{valid: 1'b1, addr: push_addr,
                            data: push_data, be: push_be};
      tail_d            = tail_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WB_DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Valid entries form a contiguous run starting at head, so walking from
  // head applies them oldest to newest and the newest writer wins per lane.
  // An entry being drained this cycle is still valid here.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = head_q;
    lookup_data = lookup_base;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (entries_q[idx].valid && (entries_q[idx].addr == lookup_addr)) begin
        lookup_data = merge_bytes(lookup_data, entries_q[idx].data,
                                  entries_q[idx].be);
      end
    end
  end

  assign head_addr = entries_q[head_q].addr;
  assign head_data = entries_q[head_q].data;
  assign head_be   = entries_q[head_q].be;
  assign count     = count_q;

endmodule

// File: rtl/arm_dmem_responder.sv
// Data-memory responder for the MEM-stage memory port.
//   clk          : single clock, all state on posedge
//   rst          : asynchronous active-high reset
//   mem_addr     : word address; only the low ADDR_W bits are decoded
//   mem_write_en : byte-lane write enables, nonzero means store
//   mem_rd_en    : load in progress; blocks the write-buffer drain
//   mem_data_in  : lane-aligned store data
//   mem_data_out : combinational read word with buffered stores forwarded
//   mem_stall    : store refused this cycle, core must hold it
//   mem_ready    : zero-fill after reset has completed
// After reset the array is cleared one word per cycle; stores are posted
// into arm_dmem_wbuf and drained through the single array write port in
// cycles without a load.
module arm_dmem_responder
  import arm_dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] mem_addr,
  input  logic [3:0]  mem_write_en,
  input  logic        mem_rd_en,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_data_out,
  output logic        mem_stall,
  output logic        mem_ready
);

  dmem_state_t       state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;

  logic [31:0]       mem_q [DEPTH];

  logic              run;
  logic [ADDR_W-1:0] word_addr;
  logic              unused_addr_hi;
  logic              is_store;
  logic              wb_full;
  logic              drain;
  logic              accept;
  logic [CNT_W-1:0]  wb_count;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_data;
  logic [3:0]        head_be;
  logic [31:0]       fwd_data;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [31:0]       arr_wdata;
  logic [3:0]        arr_wbe;

  assign run            = (state_q == DM_RUN);
  assign word_addr      = mem_addr[ADDR_W-1:0];
  assign unused_addr_hi = ^mem_addr[29:ADDR_W];

  // Arbitration: a drain needs the write port, which a load blocks. A full
  // buffer still takes a store when the head drains in the same cycle.
  assign is_store  = (mem_write_en != 4'b0000);
  assign wb_full   = (wb_count == CNT_W'(WB_DEPTH));
  assign drain     = run && (wb_count != '0) && !mem_rd_en;
  assign accept    = run && is_store && (!wb_full || drain);
  assign mem_stall = !run || (is_store && !accept);

  // Init sequencer: one array word cleared per cycle, then RUN until reset.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    case (state_q)
      DM_INIT: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = DM_RUN;
          ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DM_INIT;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  assign mem_ready = ready_q;

  // Single array write port: zero-fill during INIT, otherwise the drain.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = '0;
    arr_wdata = '0;
    arr_wbe   = 4'b0000;
    if (state_q == DM_INIT) begin
      arr_we    = 1'b1;
      arr_waddr = clr_ptr_q;
      arr_wbe   = 4'b1111;
    end else if (drain) begin
      arr_we    = 1'b1;
      arr_waddr = head_addr;
      arr_wdata = head_data;
      arr_wbe   = head_be;
    end
  end

  // NOTE: the array has no reset; the INIT sequencer clears it instead,
  // which keeps it mappable onto a RAM macro with byte-lane enables.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      for (int i = 0; i < 4; i++) begin
        if (arr_wbe[i]) mem_q[arr_waddr][8*i +: 8] <= arr_wdata[8*i +: 8];
      end
    end
  end

  arm_dmem_wbuf u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .push        (accept),
    .push_addr   (word_addr),
    .push_data   (mem_data_in),
    .push_be     (mem_write_en),
    .pop         (drain),
    .lookup_addr (word_addr),
    .lookup_base (mem_q[word_addr]),
    .lookup_data (fwd_data),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .head_be     (head_be),
    .count       (wb_count)
  );

  assign mem_data_out = run ? fwd_data : 32'h0;

endmodule

// File: tb/tb_arm_dmem_responder.sv
// Self-checking bench for arm_dmem_responder: directed vector table,
// hand-written reset sequences, and random traffic against a queue-based
// reference model of the memory and its posted-store buffer.
module tb_arm_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WBD   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] mem_addr = '0;
  logic [3:0]  mem_write_en = '0;
  logic        mem_rd_en = 1'b0;
  logic [31:0] mem_data_in = '0;
  logic [31:0] mem_data_out;
  logic        mem_stall;
  logic        mem_ready;

  arm_dmem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_write_en (mem_write_en),
    .mem_rd_en    (mem_rd_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_stall    (mem_stall),
    .mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ref_st_t;

  logic [31:0] ref_mem [DEPTH];
  ref_st_t     ref_q [$];
  int          init_cnt;
  bit          m_ready;

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] r;
    if (!m_ready) return 32'h0;
    r = ref_mem[a];
    foreach (ref_q[i]) begin
      if (ref_q[i].addr == a) begin
        for (int l = 0; l < 4; l++)
          if (ref_q[i].be[l]) r[8*l +: 8] = ref_q[i].data[8*l +: 8];
      end
    end
    return r;
  endfunction

  function automatic bit model_stall(input logic [3:0] we, input logic rd);
    if (!m_ready) return 1'b1;
    return (we != 4'b0) && (ref_q.size() == WBD) && rd;
  endfunction

  task automatic model_reset();
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    ref_q.delete();
    init_cnt = 0;
    m_ready  = 1'b0;
  endtask

  task automatic model_step(input int a, input logic [3:0] we, input logic rd,
                            input logic [31:0] d);
    bit      st;
    ref_st_t e;
    if (!m_ready) begin
      init_cnt++;
      if (init_cnt == DEPTH) m_ready = 1'b1;
      return;
    end
    st = model_stall(we, rd);
    if (ref_q.size() > 0 && !rd) begin
      e = ref_q.pop_front();
      for (int l = 0; l < 4; l++)
        if (e.be[l]) ref_mem[e.addr][8*l +: 8] = e.data[8*l +: 8];
    end
    if (we != 4'b0 && !st) ref_q.push_back('{addr: a, data: d, be: we});
  endtask

  // ---------------- cycle driver ----------------
  logic [31:0] smp_out;
  logic        smp_stall;
  logic        smp_ready;

  // Called just after a posedge: drive, sample at the negedge, compare with
  // the model, cross the next posedge, then advance the model.
  task automatic cyc(input logic [29:0] a, input logic [3:0] we,
                     input logic rd, input logic [31:0] d);
    int ai;
    ai           = int'(a[9:0]);
    mem_addr     = a;
    mem_write_en = we;
    mem_rd_en    = rd;
    mem_data_in  = d;
    #4;
    smp_out   = mem_data_out;
    smp_stall = mem_stall;
    smp_ready = mem_ready;
    check("model_out",   smp_out,   model_read(ai));
    check("model_stall", 32'(smp_stall), 32'(model_stall(we, rd)));
    check("model_ready", 32'(smp_ready), 32'(m_ready));
    @(posedge clk);
    #1;
    model_step(ai, we, rd, d);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    mem_write_en = '0;
    mem_rd_en    = 1'b0;
    #4;
    check("rst_out",   mem_data_out,     32'h0);
    check("rst_stall", 32'(mem_stall),   32'h1);
    check("rst_ready", 32'(mem_ready),   32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [29:0] addr;
    logic [3:0]  we;
    logic        rd;
    logic [31:0] din;
    logic [31:0] exp_out;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic [29:0] a, input logic [3:0] we, input logic rd,
                     input logic [31:0] d, input logic [31:0] eo, input logic es);
    vecs.push_back('{addr: a, we: we, rd: rd, din: d, exp_out: eo, exp_stall: es});
  endtask

  int          ready_at;
  logic [31:0] r_hi, r_lo, r_d;
  logic [29:0] r_a;
  logic [3:0]  r_we;
  logic        r_rd;

  task automatic rand_inputs();
    r_lo = 32'($urandom_range(0, 7));
    r_hi = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
    r_a  = {r_hi[19:0], r_lo[9:0]};
    r_we = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
    r_rd = 1'($urandom_range(0, 1));
    r_d  = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    // Store and load in one cycle: read shows old data. Forwarding, merge.
    add(30'd5, 4'hF, 1'b0, 32'hAABBCCDD, 32'h00000000, 1'b0);
    add(30'd5, 4'h0, 1'b1, 32'h0,        32'hAABBCCDD, 1'b0);
    add(30'd7, 4'hF, 1'b1, 32'h11223344, 32'h00000000, 1'b0);
    add(30'd7, 4'h1, 1'b1, 32'h000000EE, 32'h11223344, 1'b0);
    add(30'd7, 4'h0, 1'b1, 32'h0,        32'h112233EE, 1'b0);
    for (int i = 0; i < 3; i++) add(30'd7, 4'h0, 1'b0, 32'h0, 32'h112233EE, 1'b0);
    add(30'd7, 4'h0, 1'b1, 32'h0,        32'h112233EE, 1'b0);
    add(30'd5, 4'h0, 1'b1, 32'h0,        32'hAABBCCDD, 1'b0);
    // Fill with loads held, fifth store stalls; dropping the load un-stalls.
    for (int i = 0; i < 4; i++)
      add(30'(20 + i), 4'hF, 1'b1, {4{8'(20 + i)}}, 32'h0, 1'b0);
    add(30'd24, 4'hF, 1'b1, 32'h18181818, 32'h0, 1'b1);
    add(30'd24, 4'hF, 1'b0, 32'h18181818, 32'h0, 1'b0);
    add(30'd25, 4'hF, 1'b1, 32'h19191919, 32'h0, 1'b1);
    add(30'd25, 4'hF, 1'b0, 32'h19191919, 32'h0, 1'b0);
    add(30'd21, 4'h0, 1'b1, 32'h0,        32'h15151515, 1'b0);
    add(30'd26, 4'hF, 1'b1, 32'h1A1A1A1A, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) add(30'd22, 4'h0, 1'b0, 32'h0, 32'h16161616, 1'b0);
    add(30'd25, 4'h0, 1'b1, 32'h0,        32'h19191919, 1'b0);
    add(30'd24, 4'h0, 1'b1, 32'h0,        32'h18181818, 1'b0);
    add(30'd20, 4'h0, 1'b1, 32'h0,        32'h14141414, 1'b0);
    // Upper address bits alias; top word of the array.
    add(30'h2000_0005, 4'h4, 1'b1, 32'h00770000, 32'hAABBCCDD, 1'b0);
    add(30'd5,    4'h0, 1'b1, 32'h0,        32'hAA77CCDD, 1'b0);
    add(30'h3FF,  4'h8, 1'b1, 32'h99000000, 32'h00000000, 1'b0);
    add(30'h3FF,  4'h0, 1'b1, 32'h0,        32'h99000000, 1'b0);
    add(30'd0,    4'h0, 1'b0, 32'h0,        32'h00000000, 1'b0);
    add(30'd0,    4'h0, 1'b0, 32'h0,        32'h00000000, 1'b0);
    add(30'h3FF,  4'h0, 1'b1, 32'h0,        32'h99000000, 1'b0);
    add(30'h3FFF_FFFF, 4'h0, 1'b1, 32'h0,   32'h99000000, 1'b0);
    add(30'd5,    4'h0, 1'b1, 32'h0,        32'hAA77CCDD, 1'b0);

    // Reset, then ready exactly DEPTH cycles after release.
    do_reset();
    ready_at = -1;
    for (int n = 0; n < DEPTH + 50 && ready_at < 0; n++) begin
      cyc(30'(n), 4'h0, 1'b0, 32'h0);
      if (smp_ready) ready_at = n;
    end
    check("init_cycles", 32'(ready_at), 32'(DEPTH));
    for (int i = 0; i < 3; i++) begin
      cyc(30'($urandom_range(0, DEPTH - 1)), 4'h0, 1'b1, 32'h0);
      check("zero_after_init", smp_out, 32'h0);
    end

    foreach (vecs[i]) begin
      cyc(vecs[i].addr, vecs[i].we, vecs[i].rd, vecs[i].din);
      check($sformatf("vec%0d_out", i),   smp_out,         vecs[i].exp_out);
      check($sformatf("vec%0d_stall", i), 32'(smp_stall),  32'(vecs[i].exp_stall));
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cyc(r_a, r_we, r_rd, r_d);
    end

    // Queued stores are discarded by a reset; requests ignored during INIT.
    for (int i = 0; i < 6; i++) cyc(30'd0, 4'h0, 1'b0, 32'h0);
    cyc(30'd40, 4'hF, 1'b1, 32'hDEADBEEF);
    check("q40_stall", 32'(smp_stall), 32'h0);
    cyc(30'd41, 4'hF, 1'b1, 32'hCAFEF00D);
    check("q41_stall", 32'(smp_stall), 32'h0);
    cyc(30'd40, 4'h0, 1'b1, 32'h0);
    check("q40_fwd", smp_out, 32'hDEADBEEF);
    do_reset();
    for (int n = 0; n < DEPTH; n++) begin
      rand_inputs();
      cyc(r_a, r_we, r_rd, r_d);
      check("init_out_zero", smp_out, 32'h0);
    end
    cyc(30'd40, 4'h0, 1'b1, 32'h0);
    check("ready_after_rst", 32'(smp_ready), 32'h1);
    check("rst_discard40", smp_out, 32'h0);
    cyc(30'd41, 4'h0, 1'b1, 32'h0);
    check("rst_discard41", smp_out, 32'h0);
    cyc(30'd5, 4'h0, 1'b1, 32'h0);
    check("rst_zero5", smp_out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
